// File: rtl/hash_flow_bucket_nway.sv
`default_nettype none
// ============================================================================
// Module   : hash_flow_bucket_nway
// Purpose  : N-way set-associative flow table (search / insert / delete / clear)
// Revision : 1.0 - initial release
// ============================================================================
module hash_flow_bucket_nway #(
  parameter int HASH_W = 12,
  parameter int WAYS   = 2,
  parameter int KEY_W  = 96,
  parameter int RES_W  = 16,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              se_req,
  input  logic [HASH_W-1:0] se_hash,
  input  logic [KEY_W-1:0]  se_key,
  output logic              se_ack,
  output logic              se_nak,
  output logic [RES_W-1:0]  se_result,
  output logic [WAY_W-1:0]  se_way,
  input  logic              upd_req,
  input  logic              upd_op,
  input  logic [HASH_W-1:0] upd_hash,
  input  logic [KEY_W-1:0]  upd_key,
  input  logic [RES_W-1:0]  upd_result,
  output logic              upd_ack,
  output logic              upd_nak,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH  = 1 << HASH_W;
  localparam int WORD_W = 1 + KEY_W + RES_W;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_RD    = 3'd2,
    S_CMP   = 3'd3,
    S_RESP  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic [HASH_W-1:0] r_addr;
  logic [HASH_W-1:0] r_hash;
  logic [KEY_W-1:0]  r_key;
  logic [RES_W-1:0]  r_res;
  logic              r_upd;
  logic              r_del;
  logic              r_clr_pend;
  logic [WAYS-1:0]   r_hit;
  logic [WAYS-1:0]   r_free;

  logic [WORD_W-1:0] w_rdata [WAYS];
  logic [WAYS-1:0]   w_way_hit;
  logic [WAYS-1:0]   w_way_free;
  logic              w_clr_now;
  logic              w_accept;
  logic              w_hit_any;
  logic              w_free_any;
  logic [WAY_W-1:0]  w_hit_idx;
  logic [WAY_W-1:0]  w_free_idx;
  logic [WAY_W-1:0]  w_tgt_idx;
  logic [RES_W-1:0]  w_hit_res;
  logic              w_wr_upd;
  logic [WAYS-1:0]   w_we;
  logic [HASH_W-1:0] w_waddr;
  logic [WORD_W-1:0] w_wdata;

  // A clear requested mid-operation is remembered and served once the op retires.
  assign w_clr_now = r_clr_pend | clr_req;
  assign w_accept  = (r_state == S_IDLE) && !w_clr_now && (upd_req || se_req);
  assign busy      = (r_state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (&r_addr) w_next = S_IDLE;
      S_IDLE:  begin
        if (w_clr_now)              w_next = S_CLEAR;
        else if (upd_req || se_req) w_next = S_RD;
      end
      S_RD:    w_next = S_CMP;
      S_CMP:   w_next = S_RESP;
      S_RESP:  w_next = S_HOLD;
      S_HOLD:  w_next = w_clr_now ? S_CLEAR : S_IDLE;
      default: w_next = S_CLEAR;
    endcase
  end

  // Lowest index wins among hitting ways and among free ways.
  always_comb begin
    w_hit_idx  = '0;
    w_free_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_hit[i])  w_hit_idx  = WAY_W'(i);
      if (r_free[i]) w_free_idx = WAY_W'(i);
    end
    w_hit_any  = |r_hit;
    w_free_any = |r_free;
    w_tgt_idx  = w_hit_any ? w_hit_idx : w_free_idx;
    w_hit_res  = w_rdata[w_hit_idx][RES_W-1:0];
  end

  always_comb begin
    w_wr_upd = (r_state == S_RESP) && r_upd && (w_hit_any || (!r_del && w_free_any));
    w_waddr  = (r_state == S_CLEAR) ? r_addr : r_hash;
    w_wdata  = '0;
    if ((r_state == S_RESP) && !r_del) w_wdata = {1'b1, r_key, r_res};
    w_we = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_we[i] = (r_state == S_CLEAR) || (w_wr_upd && (w_tgt_idx == WAY_W'(i)));
    end
  end

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_way
      logic [WORD_W-1:0] r_mem [DEPTH];
      logic [WORD_W-1:0] r_rd;

      always_ff @(posedge clk) begin
        if (w_we[g]) r_mem[w_waddr] <= w_wdata;
        r_rd <= r_mem[r_hash];
      end

      assign w_rdata[g]    = r_rd;
      assign w_way_hit[g]  = r_rd[WORD_W-1] && (r_rd[RES_W +: KEY_W] == r_key);
      assign w_way_free[g] = ~r_rd[WORD_W-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_hash     <= '0;
      r_key      <= '0;
      r_res      <= '0;
      r_upd      <= 1'b0;
      r_del      <= 1'b0;
      r_clr_pend <= 1'b0;
      r_hit      <= '0;
      r_free     <= '0;
      se_ack     <= 1'b0;
      se_nak     <= 1'b0;
      se_result  <= '0;
      se_way     <= '0;
      upd_ack    <= 1'b0;
      upd_nak    <= 1'b0;
    end else begin
      se_ack  <= 1'b0;
      se_nak  <= 1'b0;
      upd_ack <= 1'b0;
      upd_nak <= 1'b0;
      r_addr  <= (r_state == S_CLEAR) ? r_addr + 1'b1 : '0;

      if (r_state == S_CLEAR)                    r_clr_pend <= 1'b0;
      else if (clr_req && (r_state != S_IDLE))   r_clr_pend <= 1'b1;

      if (w_accept) begin
        r_upd  <= upd_req;
        r_del  <= upd_op;
        r_res  <= upd_result;
        r_hash <= upd_req ? upd_hash : se_hash;
        r_key  <= upd_req ? upd_key  : se_key;
      end

      if (r_state == S_CMP) begin
        r_hit  <= w_way_hit;
        r_free <= w_way_free;
      end

      if (r_state == S_RESP) begin
        if (r_upd) begin
          upd_ack <= w_wr_upd;
          upd_nak <= !w_wr_upd;
        end else if (w_hit_any) begin
          se_ack    <= 1'b1;
          se_result <= w_hit_res;
          se_way    <= w_hit_idx;
        end else begin
          se_nak <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hash_flow_bucket_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_flow_bucket_nway
// Purpose  : Directed bench with a transaction-level table model and per-cycle compare
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_flow_bucket_nway;

  localparam int HASH_W = 12;
  localparam int WAYS   = 2;
  localparam int KEY_W  = 96;
  localparam int RES_W  = 16;
  localparam int DEPTH  = 1 << HASH_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              se_req = 1'b0;
  logic [HASH_W-1:0] se_hash = '0;
  logic [KEY_W-1:0]  se_key = '0;
  logic              se_ack, se_nak;
  logic [RES_W-1:0]  se_result;
  logic [0:0]        se_way;
  logic              upd_req = 1'b0;
  logic              upd_op = 1'b0;
  logic [HASH_W-1:0] upd_hash = '0;
  logic [KEY_W-1:0]  upd_key = '0;
  logic [RES_W-1:0]  upd_result = '0;
  logic              upd_ack, upd_nak;
  logic              clr_req = 1'b0;
  logic              busy;

  hash_flow_bucket_nway #(.HASH_W(HASH_W), .WAYS(WAYS), .KEY_W(KEY_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst),
    .se_req(se_req), .se_hash(se_hash), .se_key(se_key),
    .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result), .se_way(se_way),
    .upd_req(upd_req), .upd_op(upd_op), .upd_hash(upd_hash), .upd_key(upd_key),
    .upd_result(upd_result), .upd_ack(upd_ack), .upd_nak(upd_nak),
    .clr_req(clr_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Table model: plain arrays indexed by bucket and way.
  bit               mv [DEPTH][WAYS];
  logic [KEY_W-1:0] mk [DEPTH][WAYS];
  logic [RES_W-1:0] mr [DEPTH][WAYS];

  int vectors = 0, miscompares = 0, prints = 0;
  int exp_se_cyc = -1, exp_upd_cyc = -1;
  bit exp_se_hit = 0, exp_upd_ok = 0;
  logic [RES_W-1:0] exp_res = '0;
  logic exp_way = 1'b0;
  int bstart = 0, bend = 0;
  logic [RES_W-1:0] held_res = '0;
  logic held_way = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, act, exp);
      end
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < DEPTH; b++)
      for (int w = 0; w < WAYS; w++) begin
        mv[b][w] = 0; mk[b][w] = '0; mr[b][w] = '0;
      end
  endtask

  task automatic model_search(input logic [HASH_W-1:0] h, input logic [KEY_W-1:0] k,
                              output bit hit, output logic [RES_W-1:0] res, output logic way);
    hit = 0; res = '0; way = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && mv[h][w] && mk[h][w] == k) begin
        hit = 1; res = mr[h][w]; way = w[0];
      end
  endtask

  task automatic model_update(input bit del, input logic [HASH_W-1:0] h,
                              input logic [KEY_W-1:0] k, input logic [RES_W-1:0] r, output bit ok);
    int slot;
    slot = -1;
    for (int w = 0; w < WAYS; w++)
      if (slot < 0 && mv[h][w] && mk[h][w] == k) slot = w;
    if (slot < 0 && !del)
      for (int w = 0; w < WAYS; w++)
        if (slot < 0 && !mv[h][w]) slot = w;
    ok = (slot >= 0);
    if (ok) begin
      mv[h][slot] = !del; mk[h][slot] = k; mr[h][slot] = r;
    end
  endtask

  always @(negedge clk) begin : p_cmp
    bit e_busy, e_sa, e_sn, e_ua, e_un;
    logic [RES_W-1:0] e_res;
    logic e_way;
    if (cyc > 0) begin
      if (rst_q) begin
        e_busy = 1; e_sa = 0; e_sn = 0; e_ua = 0; e_un = 0;
        e_res = '0; e_way = 1'b0;
      end else begin
        e_busy = (cyc >= bstart) && (cyc < bend);
        e_sa = (cyc == exp_se_cyc) && exp_se_hit;
        e_sn = (cyc == exp_se_cyc) && !exp_se_hit;
        e_ua = (cyc == exp_upd_cyc) && exp_upd_ok;
        e_un = (cyc == exp_upd_cyc) && !exp_upd_ok;
        e_res = e_sa ? exp_res : held_res;
        e_way = e_sa ? exp_way : held_way;
      end
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("se_ack", {31'd0, se_ack}, {31'd0, e_sa});
      chk("se_nak", {31'd0, se_nak}, {31'd0, e_sn});
      chk("upd_ack", {31'd0, upd_ack}, {31'd0, e_ua});
      chk("upd_nak", {31'd0, upd_nak}, {31'd0, e_un});
      chk("se_result", {16'd0, se_result}, {16'd0, e_res});
      chk("se_way", {31'd0, se_way}, {31'd0, e_way});
      held_res = e_res;
      held_way = e_way;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (((cyc >= bstart) && (cyc < bend)) || rst) begin
      @(negedge clk);
      n++;
      if (n > 10000) begin
        chk("idle_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  // kind: 0 search, 1 insert, 2 delete. Returns the response seen at the ack/nak cycle.
  task automatic run_op(input int kind, input logic [HASH_W-1:0] h, input logic [KEY_W-1:0] k,
                        input logic [RES_W-1:0] r, input bit clr_mid, input bit rst_mid,
                        output bit ack, output bit nak, output logic [RES_W-1:0] res,
                        output logic way);
    bit got, aborted, hit, ok;
    logic [RES_W-1:0] pres;
    logic pway;
    got = 0; aborted = 0; ack = 0; nak = 0; res = '0; way = 1'b0;
    wait_idle();
    if (kind == 0) begin
      model_search(h, k, hit, pres, pway);
      exp_se_hit = hit; exp_res = pres; exp_way = pway; exp_se_cyc = cyc + 4;
      se_hash = h; se_key = k; se_req = 1'b1;
    end else begin
      model_update(kind == 2, h, k, r, ok);
      exp_upd_ok = ok; exp_upd_cyc = cyc + 4;
      upd_op = (kind == 2); upd_hash = h; upd_key = k; upd_result = r; upd_req = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        se_hash = ~h; se_key = ~k; upd_hash = ~h; upd_key = ~k; upd_result = ~r;
      end
      if (clr_mid && i == 1) clr_req = 1'b1;
      if (clr_mid && i == 2) clr_req = 1'b0;
      if (rst_mid && i == 1) begin
        rst = 1'b1; upd_req = 1'b0; exp_upd_cyc = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0; bstart = cyc; bend = cyc + DEPTH;
        model_clear();
        aborted = 1;
        break;
      end
      if (kind == 0 ? (se_ack || se_nak) : (upd_ack || upd_nak)) begin
        got = 1;
        ack = (kind == 0) ? se_ack : upd_ack;
        nak = (kind == 0) ? se_nak : upd_nak;
        res = se_result; way = se_way[0];
      end
    end
    if (!got && !aborted) chk("resp_timeout", 32'd1, 32'd0);
    se_req = 1'b0; upd_req = 1'b0;
    if (clr_mid && got) begin
      bstart = cyc + 1; bend = cyc + 1 + DEPTH;
      model_clear();
    end
    @(negedge clk);
  endtask

  task automatic run_both(input logic [HASH_W-1:0] h, input logic [KEY_W-1:0] ku,
                          input logic [RES_W-1:0] ru, input logic [KEY_W-1:0] ks,
                          output bit ua, output bit sa, output logic [RES_W-1:0] sres);
    bit ok, hit, gu, gs;
    logic [RES_W-1:0] pres;
    logic pway;
    ua = 0; sa = 0; sres = '0; gu = 0; gs = 0;
    wait_idle();
    model_update(1'b0, h, ku, ru, ok);
    model_search(h, ks, hit, pres, pway);
    exp_upd_ok = ok; exp_upd_cyc = cyc + 4;
    exp_se_hit = hit; exp_res = pres; exp_way = pway; exp_se_cyc = cyc + 9;
    upd_op = 1'b0; upd_hash = h; upd_key = ku; upd_result = ru; upd_req = 1'b1;
    se_hash = h; se_key = ks; se_req = 1'b1;
    for (int i = 0; i < 30 && !gs; i++) begin
      @(negedge clk);
      if (!gu && (upd_ack || upd_nak)) begin
        gu = 1; ua = upd_ack; upd_req = 1'b0;
      end
      if (se_ack || se_nak) begin
        gs = 1; sa = se_ack; sres = se_result; se_req = 1'b0;
      end
    end
    if (!gu || !gs) chk("both_timeout", 32'd1, 32'd0);
    se_req = 1'b0; upd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_idle();
    wait_idle();
    clr_req = 1'b1;
    bstart = cyc + 1; bend = cyc + 1 + DEPTH;
    model_clear();
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
    chk(n, act, exp);
  endtask

  localparam logic [KEY_W-1:0] K1 = {48'h60beb403644d, 48'h60beb403060e};
  localparam logic [KEY_W-1:0] KA = {48'h0000000000a1, 48'h0000000000b1};
  localparam logic [KEY_W-1:0] KB = {48'h0000000000a2, 48'h0000000000b2};
  localparam logic [KEY_W-1:0] KC = {48'h0000000000a3, 48'h0000000000b3};
  localparam logic [KEY_W-1:0] KD = {48'h0000000000a4, 48'h0000000000b4};

  initial begin : p_stim
    bit a, n, ua, sa;
    logic [RES_W-1:0] res;
    logic way;
    logic [KEY_W-1:0] kf;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bstart = cyc; bend = cyc + DEPTH;

    run_op(0, 12'h68E, K1, 16'h0, 0, 0, a, n, res, way);
    lit("post_rst_nak", {31'd0, n}, 32'd1);
    lit("post_rst_res", {16'd0, res}, 32'd0);

    run_op(1, 12'h68E, K1, 16'h0002, 0, 0, a, n, res, way);
    lit("ins_k1_ack", {31'd0, a}, 32'd1);
    run_op(0, 12'h68E, K1, 16'h0, 0, 0, a, n, res, way);
    lit("srch_k1_res", {16'd0, res}, 32'h0002);
    lit("srch_k1_way", {31'd0, way}, 32'd0);
    kf = K1 ^ (96'd1 << 48);
    run_op(0, 12'h68E, kf, 16'h0, 0, 0, a, n, res, way);
    lit("srch_flip_nak", {31'd0, n}, 32'd1);

    run_op(1, 12'h74D, KA, 16'h0001, 0, 0, a, n, res, way);
    run_op(1, 12'h74D, KB, 16'h0003, 0, 0, a, n, res, way);
    lit("fill_kb_ack", {31'd0, a}, 32'd1);
    run_op(1, 12'h74D, KC, 16'h0005, 0, 0, a, n, res, way);
    lit("full_nak", {31'd0, n}, 32'd1);
    run_op(1, 12'h74D, KB, 16'h0004, 0, 0, a, n, res, way);
    run_op(0, 12'h74D, KB, 16'h0, 0, 0, a, n, res, way);
    lit("over_res", {16'd0, res}, 32'h0004);
    lit("over_way", {31'd0, way}, 32'd1);

    run_op(2, 12'h74D, KA, 16'h0, 0, 0, a, n, res, way);
    lit("del_ka_ack", {31'd0, a}, 32'd1);
    run_op(0, 12'h74D, KA, 16'h0, 0, 0, a, n, res, way);
    run_op(1, 12'h74D, KD, 16'h0007, 0, 0, a, n, res, way);
    run_op(0, 12'h74D, KD, 16'h0, 0, 0, a, n, res, way);
    lit("kd_way0", {31'd0, way}, 32'd0);
    run_op(2, 12'h74D, KC, 16'h0, 0, 0, a, n, res, way);
    lit("del_absent_nak", {31'd0, n}, 32'd1);

    for (int i = 1; i < 7; i++)
      run_op(1, HASH_W'(i * 291), {48'(i), 48'hc0ffee}, RES_W'(i * 17), 0, 0, a, n, res, way);
    for (int i = 1; i < 7; i++)
      run_op(0, HASH_W'(i * 291), {48'(i), 48'hc0ffee}, 16'h0, 0, 0, a, n, res, way);

    run_both(12'h74D, KB, 16'h0009, KB, ua, sa, res);
    lit("both_upd_ack", {31'd0, ua}, 32'd1);
    lit("both_se_res", {16'd0, res}, 32'h0009);

    run_op(0, 12'h74D, KD, 16'h0, 1, 0, a, n, res, way);
    lit("clr_mid_ack", {31'd0, a}, 32'd1);
    run_op(0, 12'h68E, K1, 16'h0, 0, 0, a, n, res, way);
    lit("after_clr_k1", {31'd0, n}, 32'd1);
    run_op(0, 12'h74D, KB, 16'h0, 0, 0, a, n, res, way);

    run_op(1, 12'h200, KA, 16'h0011, 0, 0, a, n, res, way);
    clear_idle();
    run_op(0, 12'h200, KA, 16'h0, 0, 0, a, n, res, way);
    lit("clr_idle_nak", {31'd0, n}, 32'd1);

    run_op(1, 12'h123, KC, 16'h0033, 0, 1, a, n, res, way);
    run_op(0, 12'h123, KC, 16'h0, 0, 0, a, n, res, way);
    lit("rst_abort_nak", {31'd0, n}, 32'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hash_flow_bucket_nway.md
# hash_flow_bucket_nway

Parametrised N-way set-associative flow table for TTE/flow classification in the switch lookup path. Stores up to WAYS entries per hash bucket, each holding a valid bit, a match key (dst MAC + src MAC) and a result word (portmap). It serves search requests from the port search engine and insert/delete requests from the management path, and performs a full-table clear after reset or on command.

## Interface
- HASH_W, 12, bucket index width; table depth 2^HASH_W buckets
- WAYS, 2, entries per bucket (1..8)
- KEY_W, 96, match key width ({smac, dmac})
- RES_W, 16, result width (portmap)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- se_req  in  1  search request, level; held until se_ack/se_nak
- se_hash  in  HASH_W  search bucket index
- se_key  in  KEY_W  search key
- se_ack  out  1  one-cycle pulse: hit
- se_nak  out  1  one-cycle pulse: miss
- se_result  out  RES_W  result of hit way; valid with se_ack
- se_way  out  clog2(WAYS) (min 1)  index of hit way; valid with se_ack
- upd_req  in  1  update request, level; held until upd_ack/upd_nak
- upd_op  in  1  0 = insert/overwrite, 1 = delete
- upd_hash  in  HASH_W  target bucket
- upd_key  in  KEY_W  entry key
- upd_result  in  RES_W  result to store (insert only)
- upd_ack  out  1  one-cycle pulse: update done
- upd_nak  out  1  one-cycle pulse: bucket full (insert) or key absent (delete)
- clr_req  in  1  one-cycle pulse: clear whole table
- busy  out  1  high during clear sweep

## Operation
- Storage: WAYS sync-read RAMs, depth 2^HASH_W, word {valid, key, result}, 1-cycle read latency, write-first irrelevant (no same-address read/write overlap).
- States: CLEAR, IDLE, RD, CMP, RESP, HOLD.
- IDLE priority: pending clear > upd_req > se_req. Clear pending = clr_req latched (sticky) while not in IDLE/CLEAR, or clr_req in IDLE.
- CLEAR: write all-zero words to address 0..2^HASH_W-1 in all ways, one address per cycle; busy=1; after last address -> IDLE, busy=0. clr_req during CLEAR ignored.
- RD: bucket address applied; CMP: per-way hit = valid & (stored key == key) registered; also free-way vector = ~valid.
- RESP, search: any hit -> se_ack, se_result/se_way from lowest-index hitting way; else se_nak, se_result/se_way hold previous value.
- RESP, insert: hit in way w -> rewrite w with {1,key,upd_result}, upd_ack; else lowest free way -> write, upd_ack; else upd_nak, no write.
- RESP, delete: hit in way w -> write valid=0 to w, upd_ack; else upd_nak.
- Multiple hits (only via external corruption): lowest index wins for all ops.
- HOLD: one dead cycle so requester can drop its level request; -> IDLE (or CLEAR if clear pending).
- Request inputs (hash, key, op, result) captured at acceptance; later changes ignored.

## Timing
- Reset values: se_ack=0, se_nak=0, se_result=0, se_way=0, upd_ack=0, upd_nak=0, busy=1; state=CLEAR, address=0. rst at any time aborts in-flight op (no ack/nak issued) and restarts sweep.
- Clear: busy high for exactly 2^HASH_W cycles after rst deasserts (or after clr_req accepted in IDLE), then low.
- Request accepted at edge E0 (IDLE, req high): E1 RAM data valid, E2 compare registered, E3 ack/nak asserted for one cycle (and RAM write for update), E4 ack/nak low, state IDLE; earliest next acceptance E5.
- Requester drops req on the edge it samples ack/nak; a req still high in IDLE at E5 is a new request.
- Throughput: one op per 5 cycles. se_req and upd_req both high in IDLE: update served first, search waits.

## Test plan
- Post-reset: busy=1 for 4096 cycles; search hash=0x68E any key -> se_nak at E3, se_result=0.
- Insert hash=0x68E key={60beb403644d,60beb403060e} result=0x0002 -> upd_ack; search same -> se_ack, se_result=0x0002, se_way=0; search with smac LSB flipped -> se_nak.
- Fill bucket 0x74D with 2 distinct keys (ways 0,1) -> both upd_ack; third key -> upd_nak; reinsert key 1 with result 0x0004 -> upd_ack, search gives 0x0004, se_way=1.
- Delete key 0 at 0x74D -> upd_ack; search key 0 -> se_nak; insert new key -> lands in way 0; delete absent key -> upd_nak.
- se_req and upd_req raised same cycle on same bucket -> upd_ack at E3, se result reflects updated entry; clr_req during search -> search completes, then busy 4096 cycles, prior entries all miss.
- Assert rst in CMP of an insert -> no upd_ack/upd_nak, busy=1, entry absent after sweep.
